fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 150 +++++++++++++++
 tb/tb_fetch_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: halfword-granular instruction fetch buffer.
// Accepts 32-bit fetch words, stores them as 16-bit halfwords in a circular
// array and presents one complete instruction per cycle to decode.
// Optional feature macro: COMPRESSED_EN (16-bit instruction support).
// With COMPRESSED_EN undefined every instruction is 32 bits, in_align is
// ignored and the presented pc is always word aligned.
module fetch_buffer #(
   parameter int DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rdata,
   input  logic        in_ready,
   input  logic        in_align,
   input  logic        in_clear,
   input  logic        in_stall,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_done,
   output logic        out_stall
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]   CAP     = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE     = (AW+1)'(1);
   localparam logic [AW:0]   TWO     = (AW+1)'(2);
   localparam logic [AW:0]   ZERO    = '0;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [15:0]   hw [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic [31:0]   rpc;
   logic          first_pending;

   logic [AW-1:0] wptr_n1;
   logic [AW-1:0] rptr_n1;
   logic [AW:0]   free;
   logic [AW:0]   needed;
   logic          half_write;
   logic [31:0]   start_pc;
   logic          do_write;
   logic          done;
   logic [AW:0]   wr_cnt;
   logic [AW:0]   rd_cnt;

   // Low pc bits are implied by word alignment; in_align is unused when
   // compressed support is compiled out.
   logic unused_inputs;
   assign unused_inputs = ^{in_pc[1:0], in_align};

   assign wptr_n1 = wptr + PTR_ONE;
   assign rptr_n1 = rptr + PTR_ONE;
   assign free    = CAP - count;

   // Instruction length decode and first-write alignment handling.
   // NOTE: every always_comb output gets a value on every path (defaults or
   // full if/else); a missing assignment would infer a latch.
   always_comb begin
`ifdef COMPRESSED_EN
      needed     = (hw[rptr][1:0] == 2'b11) ? TWO : ONE;
      half_write = first_pending && in_align;
      start_pc   = {in_pc[31:2], in_align, 1'b0};
`else
      needed     = TWO;
      half_write = 1'b0;
      start_pc   = {in_pc[31:2], 2'b00};
`endif
   end

   // Accept/consume decisions; clear suppresses both, a write needs two free
   // halfwords even when only one would be stored.
   always_comb begin
      do_write = in_ready && !in_clear && (free >= TWO);
      // count is checked first so an unwritten slot never gates out_done
      done     = (count != ZERO) && (count >= needed) && !in_stall && !in_clear;
      wr_cnt   = ZERO;
      if (do_write) begin
         wr_cnt = half_write ? ONE : TWO;
      end
      rd_cnt   = done ? needed : ZERO;
   end

   // Presented instruction, zero-extended for 16-bit and zero when idle.
   always_comb begin
      out_instr = 32'h0;
      if (done) begin
         if (needed == TWO) begin
            out_instr = {hw[rptr_n1], hw[rptr]};
         end else begin
            out_instr = {16'h0, hw[rptr]};
         end
      end
   end

   assign out_done  = done;
   assign out_pc    = rpc;
   assign out_stall = free < (AW+1)'(4);

   // Halfword storage write port.
   // NOTE: the storage array has no reset; count/pointers define which
   // entries are valid, so stale contents are never presented.
   always_ff @(posedge clock) begin
      if (do_write) begin
         if (half_write) begin
            hw[wptr] <= in_rdata[31:16];
         end else begin
            hw[wptr]    <= in_rdata[15:0];
            hw[wptr_n1] <= in_rdata[31:16];
         end
      end
   end

   // Pointer, occupancy and pc bookkeeping; clear has priority over traffic.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side sees the pre-edge value regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr          <= '0;
         rptr          <= '0;
         count         <= '0;
         rpc           <= 32'h0;
         first_pending <= 1'b1;
      end else if (in_clear) begin
         wptr          <= '0;
         rptr          <= '0;
         count         <= '0;
         first_pending <= 1'b1;
      end else begin
         if (do_write) begin
            wptr <= wptr + wr_cnt[AW-1:0];
         end
         if (done) begin
            rptr <= rptr + needed[AW-1:0];
            rpc  <= rpc + (32'(needed) << 1);
         end
         // The buffer is empty while first_pending is set, so this never
         // collides with a read-side pc advance.
         if (do_write && first_pending) begin
            rpc           <= start_pc;
            first_pending <= 1'b0;
         end
         count <= count + wr_cnt - rd_cnt;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: self-checking bench for fetch_buffer.
// Directed scenarios plus a randomized run compared against a queue-based
// halfword model. Honors COMPRESSED_EN the same way the design does.
module tb_fetch_buffer;

   localparam int DEPTH = 8;
`ifdef COMPRESSED_EN
   localparam bit COMP = 1'b1;
`else
   localparam bit COMP = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [31:0] in_pc;
   logic [31:0] in_rdata;
   logic        in_ready;
   logic        in_align;
   logic        in_clear;
   logic        in_stall;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_done;
   logic        out_stall;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_pc     (in_pc),
      .in_rdata  (in_rdata),
      .in_ready  (in_ready),
      .in_align  (in_align),
      .in_clear  (in_clear),
      .in_stall  (in_stall),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_done  (out_done),
      .out_stall (out_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: FIFO of halfwords plus the pc of the front instruction.
   logic [15:0] mq [$];
   logic [31:0] mpc;
   bit          mfirst;

   task automatic model_reset();
      mq.delete();
      mpc    = 32'h0;
      mfirst = 1'b1;
   endtask

   function automatic int m_needed();
      logic [15:0] h;
      if (!COMP || mq.size() == 0) return 2;
      h = mq[0];
      return (h[1:0] == 2'b11) ? 2 : 1;
   endfunction

   function automatic bit m_done();
      return (mq.size() >= m_needed()) && !in_stall && !in_clear;
   endfunction

   function automatic logic [31:0] m_instr();
      if (!m_done()) return 32'h0;
      if (m_needed() == 2) return {mq[1], mq[0]};
      return {16'h0, mq[0]};
   endfunction

   function automatic bit m_stall();
      return (DEPTH - mq.size()) < 4;
   endfunction

   task automatic model_edge();
      int nd;
      bit rd;
      bit wr;
      if (in_clear) begin
         mq.delete();
         mfirst = 1'b1;
      end else begin
         nd = m_needed();
         rd = m_done();
         wr = in_ready && ((DEPTH - mq.size()) >= 2);
         if (rd) begin
            repeat (nd) void'(mq.pop_front());
            mpc = mpc + 32'(2 * nd);
         end
         if (wr) begin
            if (mfirst) mpc = {in_pc[31:2], (COMP && in_align), 1'b0};
            if (mfirst && COMP && in_align) begin
               mq.push_back(in_rdata[31:16]);
            end else begin
               mq.push_back(in_rdata[15:0]);
               mq.push_back(in_rdata[31:16]);
            end
            mfirst = 1'b0;
         end
      end
   endtask

   // Advance one clock, keep the model in step, return just after the edge.
   task automatic tick();
      @(posedge clock);
      if (!reset) model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      in_pc    = 32'h0;
      in_rdata = 32'h0;
      in_ready = 1'b0;
      in_align = 1'b0;
      in_clear = 1'b0;
      in_stall = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (out_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", out_done); end
      n_checks++;
      if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", out_instr); end
      n_checks++;
      if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
      n_checks++;
      if (out_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", out_stall); end
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic test_basic();
      apply_reset();
      in_pc = 32'h100; in_rdata = 32'h0000_0013; in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %0b want 1", out_done); end
      n_checks++;
      if (out_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_instr: got %h want 00000013", out_instr); end
      n_checks++;
      if (out_pc !== 32'h100) begin n_fail++; $display("FAIL basic_pc: got %h want 00000100", out_pc); end
      tick();
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %0b want 0", out_done); end
      tick();
   endtask

   task automatic test_compressed();
      // Aligned start at the upper halfword of a word.
      in_clear = 1'b1;
      tick();
      in_clear = 1'b0;
      in_pc = 32'h200; in_align = 1'b1; in_ready = 1'b1;
      in_rdata = {16'h4505, 16'($urandom)};
      tick();
      in_ready = 1'b0; in_align = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_instr !== 32'h0000_4505) begin n_fail++; $display("FAIL align_instr: got %h want 00004505", out_instr); end
      n_checks++;
      if (out_pc !== 32'h202) begin n_fail++; $display("FAIL align_pc: got %h want 00000202", out_pc); end
      tick();
      // 16-bit instruction followed by a 32-bit one split across words.
      in_clear = 1'b1;
      tick();
      in_clear = 1'b0;
      in_pc = 32'h300; in_rdata = 32'h0013_4505; in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_instr !== 32'h0000_4505 || out_pc !== 32'h300) begin
         n_fail++; $display("FAIL split_first: got %h@%h want 00004505@00000300", out_instr, out_pc);
      end
      tick();
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b0 || out_pc !== 32'h302) begin
         n_fail++; $display("FAIL split_hold: got done=%0b pc=%h want done=0 pc=00000302", out_done, out_pc);
      end
      tick();
      in_pc = 32'h304; in_rdata = 32'h0000_0000; in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b1 || out_instr !== 32'h0000_0013 || out_pc !== 32'h302) begin
         n_fail++; $display("FAIL split_second: got %0b %h@%h want 1 00000013@00000302", out_done, out_instr, out_pc);
      end
      tick();
   endtask

   task automatic test_stall_fill();
      logic [31:0] words [3];
      words[0] = 32'h1111_0003;
      words[1] = 32'h2222_0007;
      words[2] = 32'h3333_000B;
      apply_reset();
      in_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_pc = 32'h400 + 32'(4 * i); in_rdata = words[i]; in_ready = 1'b1;
         tick();
      end
      in_ready = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall: got %0b want 1", out_stall); end
      n_checks++;
      if (out_done !== 1'b0) begin n_fail++; $display("FAIL fill_done: got %0b want 0", out_done); end
      tick();
      in_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++;
         if (out_done !== 1'b1 || out_instr !== words[i] || out_pc !== 32'h400 + 32'(4 * i)) begin
            n_fail++; $display("FAIL drain_%0d: got %0b %h@%h want 1 %h@%h", i, out_done, out_instr, out_pc, words[i], 32'h400 + 32'(4 * i));
         end
         tick();
      end
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b0 || out_stall !== 1'b0) begin
         n_fail++; $display("FAIL drain_empty: got done=%0b stall=%0b want 0 0", out_done, out_stall);
      end
      tick();
   endtask

   task automatic test_clear_priority();
      apply_reset();
      in_pc = 32'h500; in_rdata = 32'h0000_0013; in_ready = 1'b1;
      tick();
      in_pc = 32'h504; in_rdata = 32'h0000_0093; in_clear = 1'b1;
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b0 || out_instr !== 32'h0) begin
         n_fail++; $display("FAIL clear_gate: got done=%0b instr=%h want 0 0", out_done, out_instr);
      end
      tick();
      in_clear = 1'b0; in_ready = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b0 || out_stall !== 1'b0) begin
         n_fail++; $display("FAIL clear_empty: got done=%0b stall=%0b want 0 0", out_done, out_stall);
      end
      in_pc = 32'h600; in_rdata = 32'h0000_00B3; in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b1 || out_instr !== 32'h0000_00B3 || out_pc !== 32'h600) begin
         n_fail++; $display("FAIL clear_refill: got %0b %h@%h want 1 000000b3@00000600", out_done, out_instr, out_pc);
      end
      tick();
   endtask

   task automatic test_async_reset();
      apply_reset();
      in_stall = 1'b1; in_ready = 1'b1;
      in_pc = 32'h700; in_rdata = 32'h0000_0013;
      tick();
      in_pc = 32'h704; in_rdata = 32'h0000_0093;
      tick();
      in_ready = 1'b0; in_stall = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b1 || out_pc !== 32'h700) begin
         n_fail++; $display("FAIL areset_pre: got done=%0b pc=%h want 1 00000700", out_done, out_pc);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (out_done !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || out_stall !== 1'b0) begin
         n_fail++; $display("FAIL areset_outputs: got done=%0b instr=%h pc=%h stall=%0b want all 0", out_done, out_instr, out_pc, out_stall);
      end
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      tick();
      in_pc = 32'h800; in_rdata = 32'h0000_0033; in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      @(negedge clock);
      n_checks++;
      if (out_done !== 1'b1 || out_instr !== 32'h0000_0033 || out_pc !== 32'h800) begin
         n_fail++; $display("FAIL areset_refill: got %0b %h@%h want 1 00000033@00000800", out_done, out_instr, out_pc);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         in_ready = $urandom_range(0, 99) < 60;
         in_rdata = $urandom;
         if ($urandom_range(0, 1) == 1) in_rdata[1:0] = 2'b11;
         if ($urandom_range(0, 1) == 1) in_rdata[17:16] = 2'b11;
         in_pc    = $urandom & 32'hFFFF_FFFC;
         in_align = 1'($urandom_range(0, 1));
         in_stall = $urandom_range(0, 99) < ((i < 400) ? 25 : 70);
         in_clear = $urandom_range(0, 99) < 4;
         @(negedge clock);
         n_checks++;
         if (out_done !== m_done()) begin n_fail++; $display("FAIL rand_done[%0d]: got %0b want %0b", i, out_done, m_done()); end
         n_checks++;
         if (out_instr !== m_instr()) begin n_fail++; $display("FAIL rand_instr[%0d]: got %h want %h", i, out_instr, m_instr()); end
         n_checks++;
         if (out_pc !== mpc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, out_pc, mpc); end
         n_checks++;
         if (out_stall !== m_stall()) begin n_fail++; $display("FAIL rand_stall[%0d]: got %0b want %0b", i, out_stall, m_stall()); end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      model_reset();
      test_reset();
      test_basic();
      if (COMP) test_compressed();
      test_stall_fill();
      test_clear_priority();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
